// File: rtl/bru_pkg.sv
// Shared constants and types for the branch resolve unit.
// Optional statistics outputs are enabled with the BRU_STATS_EN macro.
package bru_pkg;
  localparam logic [2:0] BR_BLT  = 3'b000;
  localparam logic [2:0] BR_BGT  = 3'b001;
  localparam logic [2:0] BR_BEQ  = 3'b010;
  localparam logic [2:0] BR_BNE  = 3'b011;
  localparam logic [2:0] BR_BLTU = 3'b100;
  localparam logic [2:0] BR_BGEU = 3'b101;

  localparam int FCNT_W = 4;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} bru_state_e;
endpackage

// File: rtl/bru_compare.sv
// Combinational branch condition evaluation: one shared (DATA_W+1)-bit subtractor,
// sign- or zero-extended depending on whether the condition is signed.
module bru_compare
  import bru_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        br_sel,
  output logic              cond
);
  logic              is_signed;
  logic [DATA_W:0]   diff;
  logic              neg;
  logic              zero;

  // Codes 1xx are the unsigned conditions (and the reserved ones).
  assign is_signed = ~br_sel[2];
  assign diff = {is_signed & a[DATA_W-1], a} - {is_signed & b[DATA_W-1], b};
  assign neg  = diff[DATA_W];
  // Low bits of a-b are zero exactly when a==b.
  assign zero = ~|diff[DATA_W-1:0];

  always_comb begin
    cond = 1'b0;
    case (br_sel)
      BR_BLT:  cond = neg;
      BR_BGT:  cond = ~neg & ~zero;
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_BLTU: cond = neg;
      BR_BGEU: cond = ~neg;
      default: cond = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registers the redirect and squashes younger stages
// for FLUSH_CYCLES cycles. BRU_STATS_EN adds saturating resolved/taken counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        br_sel,
  input  logic              branch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              ex_valid,
  input  logic              stall,
  output logic              flush_o,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
`ifdef BRU_STATS_EN
  ,
  output logic [CNT_W-1:0]  resolved_cnt,
  output logic [CNT_W-1:0]  taken_cnt
`endif
);
  localparam logic [FCNT_W-1:0] FC_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  bru_state_e        state_q, state_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic              flush_d, rv_d, busy_d;
  logic [ADDR_W-1:0] pc_d;
  logic              cond, take;

  bru_compare #(.DATA_W(DATA_W)) u_cmp (
    .a      (a),
    .b      (b),
    .br_sel (br_sel),
    .cond   (cond)
  );

  // Jump wins regardless of br_sel; wrong-path EX contents are ignored while flushing.
  assign take = (state_q == IDLE) & ex_valid & ~stall & ((branch & cond) | jump);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_o;
    busy_d  = busy;
    rv_d    = 1'b0;
    pc_d    = redirect_pc;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = FLUSH;
          cnt_d   = FC_INIT;
          flush_d = 1'b1;
          busy_d  = 1'b1;
          rv_d    = 1'b1;
          pc_d    = target;
        end
      end
      FLUSH: begin
        // stall does not hold the count: squashing always completes.
        if (cnt_q == '0) begin
          state_d = IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      flush_o        <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flush_o        <= flush_d;
      busy           <= busy_d;
      redirect_valid <= rv_d;
      redirect_pc    <= pc_d;
    end
  end

`ifdef BRU_STATS_EN
  logic resolve;
  assign resolve = (state_q == IDLE) & ex_valid & ~stall & (branch | jump);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else begin
      if (resolve && resolved_cnt != '1) resolved_cnt <= resolved_cnt + 1'b1;
      if (take && taken_cnt != '1)       taken_cnt    <= taken_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: FLUSH_CYCLES=2 and FLUSH_CYCLES=1 instances.
// Covers the statistics counters when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;
  typedef struct packed {
    logic [15:0] a, b;
    logic [2:0]  sel;
    logic        br, jp;
    logic [15:0] tgt;
    logic        v, st;
  } stim_t;

  typedef struct packed {
    logic        fl, rv, bz;
    logic [15:0] pc;
  } exp_t;

  logic        clk, rst_n;
  logic [15:0] a, b, target;
  logic [2:0]  br_sel;
  logic        branch, jump, ex_valid, stall;
  logic        fl0, rv0, bz0, fl1, rv1, bz1;
  logic [15:0] pc0, pc1;
`ifdef BRU_STATS_EN
  logic [15:0] rc0, tc0;
  logic [1:0]  rc1, tc1;
`endif

  exp_t        sb[$];
  logic [3:0]  ssb[$];
  int          checks = 0;
  int          errors = 0;

  branch_resolve_unit #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .br_sel(br_sel), .branch(branch),
    .jump(jump), .target(target), .ex_valid(ex_valid), .stall(stall),
    .flush_o(fl0), .redirect_valid(rv0), .redirect_pc(pc0), .busy(bz0)
`ifdef BRU_STATS_EN
    , .resolved_cnt(rc0), .taken_cnt(tc0)
`endif
  );

  branch_resolve_unit #(.FLUSH_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .br_sel(br_sel), .branch(branch),
    .jump(jump), .target(target), .ex_valid(ex_valid), .stall(stall),
    .flush_o(fl1), .redirect_valid(rv1), .redirect_pc(pc1), .busy(bz1)
`ifdef BRU_STATS_EN
    , .resolved_cnt(rc1), .taken_cnt(tc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(input logic [15:0] a_, input logic [15:0] b_, input logic [2:0] s_,
                              input logic br_, input logic jp_, input logic [15:0] t_,
                              input logic v_, input logic st_);
    stim_t s;
    s = '{a: a_, b: b_, sel: s_, br: br_, jp: jp_, tgt: t_, v: v_, st: st_};
    return s;
  endfunction

  function automatic stim_t N();
    return S(16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endfunction

  // Jumps use reserved br_sel with a!=b so only the jump can make them taken.
  function automatic stim_t J(input logic [15:0] t);
    return S(16'h1, 16'h2, 3'b110, 1'b0, 1'b1, t, 1'b1, 1'b0);
  endfunction

  function automatic stim_t Js(input logic [15:0] t);
    return S(16'h1, 16'h2, 3'b110, 1'b0, 1'b1, t, 1'b1, 1'b1);
  endfunction

  function automatic stim_t B(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] t);
    return S(x, y, s, 1'b1, 1'b0, t, 1'b1, 1'b0);
  endfunction

  function automatic stim_t Bs(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] t);
    return S(x, y, s, 1'b1, 1'b0, t, 1'b1, 1'b1);
  endfunction

  function automatic exp_t E(input logic fl, input logic rv, input logic bz, input logic [15:0] pc);
    exp_t e;
    e = '{fl: fl, rv: rv, bz: bz, pc: pc};
    return e;
  endfunction

  task automatic drive(input stim_t s);
    a = s.a; b = s.b; br_sel = s.sel; branch = s.br; jump = s.jp;
    target = s.tgt; ex_valid = s.v; stall = s.st;
  endtask

  task automatic test_reset();
    exp_t o0, o1;
    rst_n = 1'b0;
    drive(N());
    repeat (2) @(posedge clk);
    #1;
    o0 = {fl0, rv0, bz0, pc0};
    o1 = {fl1, rv1, bz1, pc1};
    checks++;
    if (o0 !== E(0, 0, 0, 16'h0)) begin
      errors++; $display("FAIL reset dut got %h want %h", o0, E(0, 0, 0, 16'h0));
    end
    checks++;
    if (o1 !== E(0, 0, 0, 16'h0)) begin
      errors++; $display("FAIL reset dut1 got %h want %h", o1, E(0, 0, 0, 16'h0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // FLUSH_CYCLES=1: the cycle right after a redirect is squashed, the next resolves.
  task automatic test_fc1();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e, o;
    st = '{J(16'h000A), J(16'h000B), J(16'h000C), N()};
    ex = '{E(1, 1, 1, 16'h000A), E(0, 0, 0, 16'h000A), E(1, 1, 1, 16'h000C), E(0, 0, 0, 16'h000C)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = {fl1, rv1, bz1, pc1};
      checks++;
      if (o !== e) begin errors++; $display("FAIL fc1 cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_blt();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e, o;
    st = '{B(3'b000, 16'hFFFF, 16'h0001, 16'h0040), N(), N(),
           B(3'b100, 16'hFFFF, 16'h0001, 16'h0080), N()};
    ex = '{E(1, 1, 1, 16'h0040), E(1, 0, 1, 16'h0040), E(0, 0, 0, 16'h0040),
           E(0, 0, 0, 16'h0040), E(0, 0, 0, 16'h0040)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = {fl0, rv0, bz0, pc0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL blt cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_conditions();
    stim_t st[15];
    exp_t  ex[15];
    exp_t  e, o;
    st = '{B(3'b001, 16'h7FFF, 16'h8000, 16'h0100), N(), N(),
           B(3'b000, 16'h8000, 16'h7FFF, 16'h0200), N(), N(),
           B(3'b001, 16'h1234, 16'h1234, 16'h0300),
           B(3'b010, 16'h1234, 16'h1234, 16'h0044), N(), N(),
           B(3'b101, 16'h0001, 16'hFFFF, 16'h0055),
           B(3'b011, 16'h0001, 16'h0002, 16'h0066), N(), N(),
           B(3'b110, 16'h0001, 16'h0002, 16'h0077)};
    ex = '{E(1, 1, 1, 16'h0100), E(1, 0, 1, 16'h0100), E(0, 0, 0, 16'h0100),
           E(1, 1, 1, 16'h0200), E(1, 0, 1, 16'h0200), E(0, 0, 0, 16'h0200),
           E(0, 0, 0, 16'h0200),
           E(1, 1, 1, 16'h0044), E(1, 0, 1, 16'h0044), E(0, 0, 0, 16'h0044),
           E(0, 0, 0, 16'h0044),
           E(1, 1, 1, 16'h0066), E(1, 0, 1, 16'h0066), E(0, 0, 0, 16'h0066),
           E(0, 0, 0, 16'h0066)};
    for (int i = 0; i < 15; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = {fl0, rv0, bz0, pc0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL cond cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_jump_stall();
    stim_t st[8];
    exp_t  ex[8];
    exp_t  e, o;
    stim_t nv;
    nv = J(16'h00A0);
    nv.v = 1'b0;
    st = '{J(16'h0070), N(), N(), Bs(3'b010, 16'h0005, 16'h0005, 16'h0090),
           B(3'b010, 16'h0005, 16'h0005, 16'h0090), N(), N(), nv};
    ex = '{E(1, 1, 1, 16'h0070), E(1, 0, 1, 16'h0070), E(0, 0, 0, 16'h0070),
           E(0, 0, 0, 16'h0070), E(1, 1, 1, 16'h0090), E(1, 0, 1, 16'h0090),
           E(0, 0, 0, 16'h0090), E(0, 0, 0, 16'h0090)};
    for (int i = 0; i < 8; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = {fl0, rv0, bz0, pc0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL jump_stall cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  // Qualifying instructions on every flush cycle are wrong-path; stall must not extend the flush.
  task automatic test_back_to_back();
    stim_t st[7];
    exp_t  ex[7];
    exp_t  e, o;
    stim_t sn;
    sn = N();
    sn.st = 1'b1;
    st = '{J(16'h0010), J(16'h0020), J(16'h0030), N(), J(16'h0011), sn, sn};
    ex = '{E(1, 1, 1, 16'h0010), E(1, 0, 1, 16'h0010), E(0, 0, 0, 16'h0010),
           E(0, 0, 0, 16'h0010), E(1, 1, 1, 16'h0011), E(1, 0, 1, 16'h0011),
           E(0, 0, 0, 16'h0011)};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = {fl0, rv0, bz0, pc0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_flush();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e, o;
    st = '{J(16'h0077), N(), J(16'h0088), N(), N()};
    ex = '{E(1, 1, 1, 16'h0077), E(1, 0, 1, 16'h0077), E(1, 1, 1, 16'h0088),
           E(1, 0, 1, 16'h0088), E(0, 0, 0, 16'h0088)};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = {fl0, rv0, bz0, pc0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid cyc %0d got %h want %h", i, o, e); end
      if (i == 1) begin
        // Second flush cycle: reset asynchronously between edges.
        drive(N());
        #2 rst_n = 1'b0;
        #1;
        o = {fl0, rv0, bz0, pc0};
        checks++;
        if (o !== E(0, 0, 0, 16'h0)) begin
          errors++; $display("FAIL rst_mid async got %h want %h", o, E(0, 0, 0, 16'h0));
        end
        #2 rst_n = 1'b1;
      end
    end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    stim_t      st[14];
    logic [3:0] ex[14];
    logic [3:0] e, o;
    rst_n = 1'b0;
    drive(N());
    @(negedge clk);
    rst_n = 1'b1;
    st = '{Js(16'h0001), J(16'h0002), N(), B(3'b010, 16'h0001, 16'h0002, 16'h0003),
           J(16'h0004), N(), J(16'h0005), N(), J(16'h0006), N(), J(16'h0007), N(),
           B(3'b010, 16'h0001, 16'h0002, 16'h0008), B(3'b011, 16'h0003, 16'h0003, 16'h0009)};
    // {taken_cnt, resolved_cnt} with CNT_W=2, saturating at 3
    ex = '{4'b00_00, 4'b01_01, 4'b01_01, 4'b01_10, 4'b10_11, 4'b10_11, 4'b11_11,
           4'b11_11, 4'b11_11, 4'b11_11, 4'b11_11, 4'b11_11, 4'b11_11, 4'b11_11};
    for (int i = 0; i < 14; i++) begin
      drive(st[i]); ssb.push_back(ex[i]);
      @(posedge clk); #1;
      e = ssb.pop_front(); o = {tc1, rc1};
      checks++;
      if (o !== e) begin errors++; $display("FAIL stats cyc %0d got %b want %b", i, o, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fc1();
    test_blt();
    test_conditions();
    test_jump_stall();
    test_back_to_back();
    test_reset_mid_flush();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
